// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC,
// NOP encoding and PC register operations.
// Optional feature macro: FETCH_NOP_SQUASH_EN (drop NOP words before decode).
package instruction_fetch_unit_pkg;

    localparam int ADDR_W = 16;
    localparam int INSTR_W = 28;
    localparam logic [ADDR_W-1:0] FETCH_RESET_PC = 16'h0000;

    // Upper byte of a NOP word: {opcode, dest[7:4]}
    localparam logic [7:0] NOP_TAG = 8'hF0;

    typedef enum logic [1:0] {
        PC_HOLD = 2'd0,
        PC_LOAD = 2'd1,
        PC_INC  = 2'd2
    } pc_op_e;

    typedef struct packed {
        logic [3:0] opcode;
        logic [7:0] dest;
        logic [7:0] src1;
        logic [7:0] src0;
    } instr_t;

    function automatic logic is_nop(input logic [INSTR_W-1:0] word);
        return word[27:20] == NOP_TAG;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// ROM and decode-side signals of the fetch unit, bundled into one interface.
// master = fetch unit, slave = ROM/decode/execute environment.
interface instruction_fetch_unit_if #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 28
);
    logic [ADDR_W-1:0]  oRomAddress;
    logic [INSTR_W-1:0] iRomInstruction;
    logic               iHalt;
    logic               iBranchTaken;
    logic [ADDR_W-1:0]  iBranchTarget;
    logic               oInstrValid;
    logic               iDecodeReady;
    logic [INSTR_W-1:0] oInstruction;
    logic [ADDR_W-1:0]  oInstrPC;
    logic [15:0]        oFetchCount;

    modport master (
        output oRomAddress, oInstrValid, oInstruction, oInstrPC, oFetchCount,
        input  iRomInstruction, iHalt, iBranchTaken, iBranchTarget, iDecodeReady
    );

    modport slave (
        input  oRomAddress, oInstrValid, oInstruction, oInstrPC, oFetchCount,
        output iRomInstruction, iHalt, iBranchTaken, iBranchTarget, iDecodeReady
    );
endinterface

// File: rtl/instruction_fetch_unit_fetch_pc_reg.sv
// Program counter register: load / increment / hold, wraps modulo 2^ADDR_W.
import instruction_fetch_unit_pkg::*;

module fetch_pc_reg #(
    parameter int                 W        = 16,
    parameter logic [W-1:0]       RESET_PC = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  pc_op_e       i_op,
    input  logic [W-1:0] i_target,
    output logic [W-1:0] o_pc
);
    logic [W-1:0] r_pc;

    // PC update; increment wraps naturally at the register width
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pc <= RESET_PC;
        end else begin
            case (i_op)
                PC_LOAD: r_pc <= i_target;
                PC_INC:  r_pc <= r_pc + 1'b1;
                default: r_pc <= r_pc;
            endcase
        end
    end

    assign o_pc = r_pc;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: drives the ROM address from the PC, captures the
// returned word into the IR and presents it to decode via valid/ready.
// Optional feature macro: FETCH_NOP_SQUASH_EN (NOP words skipped, never presented).
import instruction_fetch_unit_pkg::*;

module instruction_fetch_unit #(
    parameter int                ADDR_W   = instruction_fetch_unit_pkg::ADDR_W,
    parameter int                INSTR_W  = instruction_fetch_unit_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = FETCH_RESET_PC
) (
    input  logic                       Clock,
    input  logic                       Reset,
    instruction_fetch_unit_if.master   bus
);
    logic [ADDR_W-1:0]  w_pc;
    pc_op_e             w_pc_op;
    logic               w_slot_free;
    logic               w_xfer;
    logic               w_squash;
    logic               w_load_ir;
    logic               w_valid_nxt;

    logic               r_valid;
    logic [INSTR_W-1:0] r_ir;
    logic [ADDR_W-1:0]  r_ir_pc;
    logic [15:0]        r_count;

    fetch_pc_reg #(
        .W        (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk    (Clock),
        .i_rst_n  (Reset),
        .i_op     (w_pc_op),
        .i_target (bus.iBranchTarget),
        .o_pc     (w_pc)
    );

    assign w_slot_free = !r_valid || bus.iDecodeReady;
    assign w_xfer      = r_valid && bus.iDecodeReady;

`ifdef FETCH_NOP_SQUASH_EN
    assign w_squash = is_nop(bus.iRomInstruction);
`else
    assign w_squash = 1'b0;
`endif

    // Edge decision: redirect beats halt beats fetch; otherwise stall
    always_comb begin
        w_pc_op     = PC_HOLD;
        w_load_ir   = 1'b0;
        w_valid_nxt = r_valid;
        if (bus.iBranchTaken) begin
            w_pc_op     = PC_LOAD;
            w_valid_nxt = 1'b0;
        end else if (bus.iHalt && w_slot_free) begin
            w_valid_nxt = 1'b0;
        end else if (w_slot_free) begin
            w_pc_op = PC_INC;
            if (w_squash) begin
                w_valid_nxt = 1'b0;
            end else begin
                w_load_ir   = 1'b1;
                w_valid_nxt = 1'b1;
            end
        end
    end

    // IR, valid flag and accepted-instruction counter
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_valid <= 1'b0;
            r_ir    <= '0;
            r_ir_pc <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_load_ir) begin
                r_ir    <= bus.iRomInstruction;
                r_ir_pc <= w_pc;
            end
            // A transfer counts even when a redirect flushes the IR on the same edge
            if (w_xfer) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.oRomAddress  = w_pc;
    assign bus.oInstrValid  = r_valid;
    assign bus.oInstruction = r_ir;
    assign bus.oInstrPC     = r_ir_pc;
    assign bus.oFetchCount  = r_count;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed + randomized bench for instruction_fetch_unit with a cycle-level
// reference model written directly from the fetch rules.
import instruction_fetch_unit_pkg::*;

module tb_instruction_fetch_unit;
    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if #(.ADDR_W(16), .INSTR_W(28)) bus ();

    instruction_fetch_unit dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    logic [27:0] rom [0:65535];
    assign bus.iRomInstruction = rom[bus.oRomAddress];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

`ifdef FETCH_NOP_SQUASH_EN
    localparam bit SQUASH = 1'b1;
`else
    localparam bit SQUASH = 1'b0;
`endif

    // reference model state
    logic [15:0] m_pc;
    logic        m_v;
    logic [27:0] m_ir;
    logic [15:0] m_ipc;
    logic [15:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance the model by one edge using the inputs currently applied
    task automatic model_edge();
        logic [27:0] w;
        if (!Reset) begin
            m_pc = 16'h0000; m_v = 1'b0; m_ir = '0; m_ipc = '0; m_cnt = '0;
        end else begin
            if (m_v && bus.iDecodeReady) m_cnt = m_cnt + 16'd1;
            if (bus.iBranchTaken) begin
                m_pc = bus.iBranchTarget;
                m_v  = 1'b0;
            end else if (!m_v || bus.iDecodeReady) begin
                if (bus.iHalt) begin
                    m_v = 1'b0;
                end else begin
                    w = rom[m_pc];
                    if (SQUASH && w[27:20] == NOP_TAG) begin
                        m_v = 1'b0;
                    end else begin
                        m_ir  = w;
                        m_ipc = m_pc;
                        m_v   = 1'b1;
                    end
                    m_pc = m_pc + 16'd1;
                end
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clock);
        #1;
        chk("rom_addr", {16'h0, bus.oRomAddress}, {16'h0, m_pc});
        chk("valid", {31'h0, bus.oInstrValid}, {31'h0, m_v});
        chk("instr", {4'h0, bus.oInstruction}, {4'h0, m_ir});
        chk("instr_pc", {16'h0, bus.oInstrPC}, {16'h0, m_ipc});
        chk("fetch_cnt", {16'h0, bus.oFetchCount}, {16'h0, m_cnt});
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            rom[i] = 28'($urandom);
            if (SQUASH && rom[i][27:20] == NOP_TAG) rom[i][20] = ~rom[i][20];
        end
        if (SQUASH) begin
            rom[8] = {NOP_TAG, 20'h12345};
            rom[9] = {NOP_TAG, 20'h0ABCD};
        end
        m_pc = '0; m_v = 1'b0; m_ir = '0; m_ipc = '0; m_cnt = '0;
        Reset = 1'b0;
        bus.iHalt = 1'b0;
        bus.iBranchTaken = 1'b0;
        bus.iBranchTarget = '0;
        bus.iDecodeReady = 1'b1;

        // reset state
        step();
        step();
        chk("rst_valid", {31'h0, bus.oInstrValid}, 32'h0);
        chk("rst_cnt", {16'h0, bus.oFetchCount}, 32'h0);
        chk("rst_instr", {4'h0, bus.oInstruction}, 32'h0);

        // streaming from reset, one per cycle
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_pc", {16'h0, bus.oInstrPC}, 32'(i));
            chk("t1_ir", {4'h0, bus.oInstruction}, {4'h0, rom[i]});
        end

        // stall at PC 5
        step();
        step();
        chk("t2_pc5", {16'h0, bus.oInstrPC}, 32'd5);
        bus.iDecodeReady = 1'b0;
        repeat (3) step();
        chk("t2_frozen_pc", {16'h0, bus.oInstrPC}, 32'd5);
        chk("t2_frozen_ir", {4'h0, bus.oInstruction}, {4'h0, rom[5]});
        chk("t2_rom_addr", {16'h0, bus.oRomAddress}, 32'd6);
        chk("t2_cnt", {16'h0, bus.oFetchCount}, 32'd5);
        bus.iDecodeReady = 1'b1;
        step();
        chk("t2_pc6", {16'h0, bus.oInstrPC}, 32'd6);
        chk("t2_cnt6", {16'h0, bus.oFetchCount}, 32'd6);

        // redirect during stall
        bus.iDecodeReady = 1'b0;
        step();
        bus.iBranchTaken = 1'b1;
        bus.iBranchTarget = 16'h0002;
        step();
        bus.iBranchTaken = 1'b0;
        chk("t3_flush", {31'h0, bus.oInstrValid}, 32'h0);
        step();
        chk("t3_tgt_v", {31'h0, bus.oInstrValid}, 32'h1);
        chk("t3_tgt_pc", {16'h0, bus.oInstrPC}, 32'd2);

        // PC wrap
        bus.iDecodeReady = 1'b1;
        bus.iBranchTaken = 1'b1;
        bus.iBranchTarget = 16'hFFFE;
        step();
        bus.iBranchTaken = 1'b0;
        step();
        chk("t4_fffe", {16'h0, bus.oInstrPC}, 32'h0000FFFE);
        step();
        chk("t4_ffff", {16'h0, bus.oInstrPC}, 32'h0000FFFF);
        step();
        chk("t4_0000", {16'h0, bus.oInstrPC}, 32'h0);
        chk("t4_ir", {4'h0, bus.oInstruction}, {4'h0, rom[0]});

        // mid-stream reset
        step();
        Reset = 1'b0;
        step();
        chk("t5_valid", {31'h0, bus.oInstrValid}, 32'h0);
        chk("t5_ir", {4'h0, bus.oInstruction}, 32'h0);
        chk("t5_pc", {16'h0, bus.oInstrPC}, 32'h0);
        chk("t5_cnt", {16'h0, bus.oFetchCount}, 32'h0);
        chk("t5_addr", {16'h0, bus.oRomAddress}, 32'h0);
        Reset = 1'b1;
        step();
        chk("t5_restart", {16'h0, bus.oInstrPC}, 32'h0);
        chk("t5_restart_v", {31'h0, bus.oInstrValid}, 32'h1);

`ifdef FETCH_NOP_SQUASH_EN
        // NOP words 8 and 9 never reach decode
        for (int k = 0; k < 20 && bus.oInstrPC !== 16'd7; k++) step();
        chk("t6_pc7", {16'h0, bus.oInstrPC}, 32'd7);
        step();
        chk("t6_gap", {31'h0, bus.oInstrValid}, 32'h0);
        step();
        step();
        chk("t6_pc10", {16'h0, bus.oInstrPC}, 32'd10);
        chk("t6_cnt", {16'h0, bus.oFetchCount}, 32'd8);
`endif

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            bus.iDecodeReady = ($urandom_range(0, 99) < 70);
            bus.iHalt        = ($urandom_range(0, 99) < 10);
            bus.iBranchTaken = ($urandom_range(0, 99) < 8);
            bus.iBranchTarget = ($urandom_range(0, 3) == 0) ? 16'hFFFD : 16'($urandom);
            Reset            = !($urandom_range(0, 99) < 2);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
